// File: rtl/sub_pkg.sv
// Shared types and sizing helpers for the bit-serial subtractor.
package sub_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int WIDTH_DEF = 8;
  localparam int CNT_W     = $clog2(WIDTH_DEF);

  // Bit-counter width for a given operand width (at least one bit).
  function automatic int cnt_w(input int width);
    return (width < 2) ? 1 : $clog2(width);
  endfunction

endpackage

// File: rtl/full_subtractor.sv
// One-bit full subtractor: d = a - b - bi, with borrow-out bo.
module full_subtractor (
  input  logic a,
  input  logic b,
  input  logic bi,
  output logic d,
  output logic bo
);

  assign d  = a ^ b ^ bi;
  assign bo = (~a & b) | (~a & bi) | (b & bi);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial D = A - B - Bi, LSB first, with start/busy/done handshake.
//   state | meaning
//   IDLE  | waiting for start; operands captured on the accepting edge
//   RUN   | one bit per clock, WIDTH clocks
//   DONE  | one-cycle done pulse; results already registered
module serial_subtractor
  import sub_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Bi,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] D,
  output logic             Bo,
  output logic             V
);

  localparam int CNT_WIDTH = cnt_w(WIDTH);
  localparam logic [CNT_WIDTH-1:0] LAST_BIT = CNT_WIDTH'(WIDTH - 1);

  state_t               r_state;
  logic [WIDTH-1:0]     r_a;
  logic [WIDTH-1:0]     r_b;
  logic [WIDTH-2:0]     r_res;
  logic                 r_br;
  logic [CNT_WIDTH-1:0] r_cnt;
  logic                 r_a_msb;
  logic                 r_b_msb;
  logic                 r_busy;
  logic                 r_done;
  logic [WIDTH-1:0]     r_d;
  logic                 r_bo;
  logic                 r_v;

  logic                 w_d;
  logic                 w_bo;

  full_subtractor u_fs (
    .a  (r_a[0]),
    .b  (r_b[0]),
    .bi (r_br),
    .d  (w_d),
    .bo (w_bo)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_a     <= '0;
      r_b     <= '0;
      r_res   <= '0;
      r_br    <= 1'b0;
      r_cnt   <= '0;
      r_a_msb <= 1'b0;
      r_b_msb <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_d     <= '0;
      r_bo    <= 1'b0;
      r_v     <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          r_done <= 1'b0;
          if (start) begin
            r_a     <= A;
            r_b     <= B;
            r_br    <= Bi;
            r_cnt   <= '0;
            r_a_msb <= A[WIDTH-1];
            r_b_msb <= B[WIDTH-1];
            r_busy  <= 1'b1;
            r_state <= RUN;
          end
        end
        RUN: begin
          r_a   <= r_a >> 1;
          r_b   <= r_b >> 1;
          // Result fills from the top; the final bit goes straight into D.
          r_res <= (WIDTH-1)'({w_d, r_res} >> 1);
          r_br  <= w_bo;
          r_cnt <= r_cnt + CNT_WIDTH'(1);
          if (r_cnt == LAST_BIT) begin
            r_d     <= {w_d, r_res};
            r_bo    <= w_bo;
            r_v     <= (r_a_msb != r_b_msb) & (w_d != r_a_msb);
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_state <= DONE;
          end
        end
        DONE: begin
          r_done  <= 1'b0;
          r_state <= IDLE;
        end
        default: begin
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign busy = r_busy;
  assign done = r_done;
  assign D    = r_d;
  assign Bo   = r_bo;
  assign V    = r_v;

endmodule
